// File: rtl/rf_write_arbiter.sv
// rtl/rf_write_arbiter.sv - round-robin write arbiter for a shared clock-enabled register bank
// Optional RF_ARB_LOCK_EN adds req_lock so a granted requester can burst on consecutive cycles.
module rf_write_arbiter #(
  parameter int NREQ = 4,
  parameter int NREG = 8,
  parameter int AW   = 3
) (
  input  logic                 clk_n,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*16-1:0]   req_data,
`ifdef RF_ARB_LOCK_EN
  input  logic [NREQ-1:0]      req_lock,
`endif
  output logic [NREQ-1:0]      ack,
  output logic                 err,
  output logic [15:0]          D,
  output logic [NREG-1:0]      clk_en,
  output logic                 busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [IW-1:0]   last;
  logic [NREQ-1:0] elig;
  logic            hold;
  logic            found;
  logic [IW-1:0]   idx;
  logic [IW-1:0]   win;
  logic [AW-1:0]   win_addr;
  logic [15:0]     win_data;
  logic            addr_ok;
  logic [NREG-1:0] win_en;

  // last always names the most recent winner, so a locked burst simply re-grants it
  always_comb begin
    hold = 1'b0;
`ifdef RF_ARB_LOCK_EN
    hold = |(ack & req & req_lock);
`endif
    elig = req & ~ack;
  end

  always_comb begin
    found = 1'b0;
    win   = last;
    idx   = last;
    if (hold) begin
      found = 1'b1;
    end else begin
      for (int k = 1; k <= NREQ; k++) begin
        idx = IW'((int'(last) + k) % NREQ);
        if (!found && elig[idx]) begin
          found = 1'b1;
          win   = idx;
        end
      end
    end
  end

  always_comb begin
    win_addr = req_addr[int'(win)*AW +: AW];
    win_data = req_data[int'(win)*16 +: 16];
    addr_ok  = (int'(win_addr) < NREG);
    win_en   = addr_ok ? (NREG'(1) << win_addr) : '0;
  end

  always_ff @(negedge clk_n or negedge rst_n) begin
    if (!rst_n) begin
      ack    <= '0;
      err    <= 1'b0;
      clk_en <= '0;
      D      <= 16'h0000;
      last   <= IW'(NREQ - 1);
    end else if (found) begin
      ack    <= NREQ'(1) << win;
      err    <= !addr_ok;
      clk_en <= win_en;
      D      <= win_data;
      last   <= win;
    end else begin
      ack    <= '0;
      err    <= 1'b0;
      clk_en <= '0;
    end
  end

  assign busy = (|clk_en) | err;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb/tb_rf_write_arbiter.sv - scoreboard bench for rf_write_arbiter
module tb_rf_write_arbiter;

  localparam int NREQ = 4;
  localparam int NREG = 6;
  localparam int AW   = 3;

  typedef struct packed {
    logic [NREQ-1:0] ack;
    logic            err;
    logic [NREG-1:0] en;
    logic [15:0]     d;
  } grant_t;

  logic               clk_n = 1'b1;
  logic               rst_n;
  logic [NREQ-1:0]    req;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*16-1:0] req_data;
`ifdef RF_ARB_LOCK_EN
  logic [NREQ-1:0]    req_lock = '0;
`endif
  logic [NREQ-1:0]    ack;
  logic               err;
  logic [15:0]        D;
  logic [NREG-1:0]    clk_en;
  logic               busy;

  logic [AW-1:0] ra [NREQ];
  logic [15:0]   rd [NREQ];
  logic [15:0]   bank [NREG];
  logic [15:0]   saved [NREG];
  grant_t        exp_q [$];
  logic          drop;
  int            checks;
  int            failures;

  rf_write_arbiter #(.NREQ(NREQ), .NREG(NREG), .AW(AW)) dut (
    .clk_n    (clk_n),
    .rst_n    (rst_n),
    .req      (req),
    .req_addr (req_addr),
    .req_data (req_data),
`ifdef RF_ARB_LOCK_EN
    .req_lock (req_lock),
`endif
    .ack      (ack),
    .err      (err),
    .D        (D),
    .clk_en   (clk_en),
    .busy     (busy)
  );

  always #5 clk_n = ~clk_n;

  // behavioural register bank sharing the falling edge
  always @(negedge clk_n) begin
    for (int r = 0; r < NREG; r++)
      if (clk_en[r]) bank[r] <= D;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic push(input logic [NREQ-1:0] a, input logic e, input logic [NREG-1:0] en,
                      input logic [15:0] d);
    grant_t g;
    g.ack = a;
    g.err = e;
    g.en  = en;
    g.d   = d;
    exp_q.push_back(g);
  endtask

  task automatic apply();
    for (int i = 0; i < NREQ; i++) begin
      req_addr[i*AW +: AW] = ra[i];
      req_data[i*16 +: 16] = rd[i];
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_n);
      #1;
      if (drop) req = req & ~ack;
    end
  endtask

  task automatic monitor();
    grant_t act;
    grant_t exp;
    logic   exp_busy;
    forever begin
      @(posedge clk_n);
      if (rst_n && (ack != '0 || err || clk_en != '0)) begin
        act = {ack, err, clk_en, D};
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_grant ack=%b err=%b clk_en=%b D=%h required=no grant",
                   ack, err, clk_en, D);
        end else begin
          exp = exp_q.pop_front();
          exp_busy = exp.err | (|exp.en);
          if (act !== exp || busy !== exp_busy)
          begin
            failures++;
            $display("FAIL grant actual ack=%b err=%b clk_en=%b D=%h busy=%b required ack=%b err=%b clk_en=%b D=%h busy=%b",
                     ack, err, clk_en, D, busy, exp.ack, exp.err, exp.en, exp.d, exp_busy);
          end
        end
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    drop     = 1'b0;
    rst_n    = 1'b0;
    ra[0] = 3'd0; ra[1] = 3'd1; ra[2] = 3'd2; ra[3] = 3'd3;
    rd[0] = 16'h1111; rd[1] = 16'h4444; rd[2] = 16'h8888; rd[3] = 16'hcccc;
    apply();
    req = 4'b1111;
    fork
      monitor();
    join_none

    // reset held with every requester asking
    tick(3);
    check("reset_ack", 32'(ack), 32'h0);
    check("reset_err", 32'(err), 32'h0);
    check("reset_clk_en", 32'(clk_en), 32'h0);
    check("reset_D", 32'(D), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    push(4'b0001, 1'b0, 6'b000001, 16'h1111);
    drop  = 1'b1;
    rst_n = 1'b1;
    tick(1);
    req = '0;
    tick(2);
    check("drained_reset", 32'(exp_q.size()), 32'h0);
    check("bank0_after_reset", 32'(bank[0]), 32'h1111);

    // single writer
    ra[2] = 3'd5; rd[2] = 16'h2222;
    apply();
    push(4'b0100, 1'b0, 6'b100000, 16'h2222);
    req = 4'b0100;
    tick(4);
    check("bank5_single", 32'(bank[5]), 32'h2222);
    check("drained_single", 32'(exp_q.size()), 32'h0);

    // round robin with wrap; pointer sits at 2 so order starts at 3
    ra[2] = 3'd2; rd[2] = 16'h8888;
    apply();
    for (int p = 0; p < 2; p++) begin
      push(4'b1000, 1'b0, 6'b001000, 16'hcccc);
      push(4'b0001, 1'b0, 6'b000001, 16'h1111);
      push(4'b0010, 1'b0, 6'b000010, 16'h4444);
      push(4'b0100, 1'b0, 6'b000100, 16'h8888);
    end
    drop = 1'b0;
    req  = 4'b1111;
    tick(8);
    req  = '0;
    drop = 1'b1;
    tick(2);
    check("drained_rr", 32'(exp_q.size()), 32'h0);
    check("bank1_rr", 32'(bank[1]), 32'h4444);
    check("bank3_rr", 32'(bank[3]), 32'hcccc);

    // two writers to the same address
    ra[0] = 3'd3; rd[0] = 16'hdddd;
    ra[1] = 3'd3; rd[1] = 16'hffff;
    apply();
    push(4'b0001, 1'b0, 6'b001000, 16'hdddd);
    push(4'b0010, 1'b0, 6'b001000, 16'hffff);
    req = 4'b0011;
    tick(4);
    check("bank3_collision", 32'(bank[3]), 32'hffff);
    check("drained_collision", 32'(exp_q.size()), 32'h0);

    // out-of-range address is acked with err and writes nothing
    ra[1] = 3'd7; rd[1] = 16'h5555;
    apply();
    for (int r = 0; r < NREG; r++) saved[r] = bank[r];
    push(4'b0010, 1'b1, 6'b000000, 16'h5555);
    req = 4'b0010;
    tick(3);
    for (int r = 0; r < NREG; r++) check("bank_unchanged_bad_addr", 32'(bank[r]), 32'(saved[r]));
    check("drained_bad_addr", 32'(exp_q.size()), 32'h0);

    // reset landing on a grant cycle cancels the write
    ra[2] = 3'd4; rd[2] = 16'h8888;
    apply();
    push(4'b0100, 1'b0, 6'b010000, 16'h8888);
    req = 4'b0100;
    tick(3);
    check("bank4_before", 32'(bank[4]), 32'h8888);
    ra[3] = 3'd4; rd[3] = 16'h1234;
    apply();
    push(4'b1000, 1'b0, 6'b010000, 16'h1234);
    req = 4'b1000;
    tick(1);
    check("clk_en_mid_grant", 32'(clk_en), 32'h10);
    rst_n = 1'b0;
    #1;
    check("clk_en_async_reset", 32'(clk_en), 32'h0);
    check("ack_async_reset", 32'(ack), 32'h0);
    check("busy_async_reset", 32'(busy), 32'h0);
    check("D_async_reset", 32'(D), 32'h0);
    tick(2);
    req   = '0;
    rst_n = 1'b1;
    tick(2);
    check("bank4_kept", 32'(bank[4]), 32'h8888);
    check("drained_final", 32'(exp_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
